// File: rtl/mem_access_pkg.sv
// mem_access_pkg: access-type encodings, FSM states and lane constants shared by the
// data-memory access controller and its lane merge unit.
package mem_access_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

    function automatic logic misaligned(input op_e op, input logic [1:0] off);
        case (op)
            OP_LH, OP_LHU, OP_SH: return off[0];
            OP_LB, OP_LBU, OP_SB: return 1'b0;
            default:              return |off;
        endcase
    endfunction

    function automatic logic is_rmw(input op_e op);
        return op == OP_SB || op == OP_SH;
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// byte_lane_merge: little-endian lane extract/extend for loads and lane insert for
// sub-word stores; purely combinational.
module byte_lane_merge
    import mem_access_pkg::*;
(
    input  op_e         op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [4:0]  sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] mask;

    always_comb begin
        sh = op_i == OP_SH ? {off_i[1], 4'b0000} : {off_i, 3'b000};
        b = 8'(word_i >> {off_i, 3'b000});
        h = off_i[1] ? word_i[31:16] : word_i[15:0];
        case (op_i)
            OP_LB:   load_o = {{24{b[7]}}, b};
            OP_LBU:  load_o = {24'b0, b};
            OP_LH:   load_o = {{16{h[15]}}, h};
            OP_LHU:  load_o = {16'b0, h};
            default: load_o = word_i;
        endcase
        mask = (op_i == OP_SH ? HALF_MASK : BYTE_MASK) << sh;
        store_o = is_rmw(op_i) ? (word_i & ~mask) | ((wdata_i << sh) & mask) : wdata_i;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer over a word-wide synchronous data
// memory; sub-word stores are done as read-modify-write.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              err_misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    op_e               op_q, op_d, op_in;
    logic [1:0]        off_q, off_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;
    logic              rv_q, rv_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              accept, bad;
    logic [31:0]       load_w, store_w;

    assign op_in  = op_e'(req_op);
    assign bad    = misaligned(op_in, req_addr[1:0]);
    assign accept = state_q == IDLE && req_valid;

    byte_lane_merge u_merge (
        .op_i   (op_q),
        .off_i  (off_q),
        .word_i (mem_rdata),
        .wdata_i(wdata_q),
        .load_o (load_w),
        .store_o(store_w)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        off_d    = off_q;
        wdata_d  = wdata_q;
        addr_d   = addr_q;
        mwdata_d = mwdata_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = bad ? DONE : op_in == OP_SW ? WRITE : RD_ADDR;
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: state_d = is_rmw(op_q) ? WRITE : DONE;
            WRITE:   state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            op_d    = op_in;
            off_d   = req_addr[1:0];
            wdata_d = req_wdata;
        end
        if (accept && !bad) addr_d = {req_addr[ADDR_W-1:2], 2'b00};
        // A full-word store goes straight from IDLE, so its data comes from the request port
        if (state_d == WRITE) mwdata_d = state_q == IDLE ? req_wdata : store_w;
        we_d    = state_d == WRITE;
        rv_d    = state_d == DONE;
        rdata_d = state_q == RD_DATA && state_d == DONE ? load_w : '0;
        err_d   = accept && bad;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_LW;
            off_q    <= '0;
            wdata_q  <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            mwdata_q <= '0;
            rv_q     <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            off_q    <= off_d;
            wdata_q  <= wdata_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            mwdata_q <= mwdata_d;
            rv_q     <= rv_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign stall        = req_valid & ~rv_q;
    assign resp_valid   = rv_q;
    assign resp_rdata   = rdata_q;
    assign err_misalign = err_q;
    assign mem_addr     = addr_q;
    assign mem_we       = we_q;
    assign mem_wdata    = mwdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of load/store sequencing, lane handling,
// misalignment, back-to-back requests and reset abort against a word memory model.
module tb_mem_access_ctrl;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        stall, resp_valid, err_misalign, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = '0;
    logic [31:0] pre_dat = '0;

    int          checks = 0, errors = 0, we_cnt = 0, rv_cnt = 0, stall_bad = 0;
    logic [31:0] we_addr = '0, we_data = '0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .stall       (stall),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .err_misalign(err_misalign),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we === 1'b1) mem[mem_addr[9:2]] <= mem_wdata;
        else if (pre_we) mem[pre_idx] <= pre_dat;
        mem_rdata <= mem[mem_addr[9:2]];
    end

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= mem_addr;
            we_data <= mem_wdata;
        end
        if (resp_valid === 1'b1) rv_cnt <= rv_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input op_e op, input logic [31:0] addr, input logic [31:0] wdata,
                          output int edges, output logic [31:0] rdata, output logic err);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (stall !== ~resp_valid) stall_bad++;
        end while (resp_valid !== 1'b1 && edges < 20);
        rdata = resp_rdata;
        err   = err_misalign;
    endtask

    task automatic idle(input string tag);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_rv_clear"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic load(input string tag, input op_e op, input logic [31:0] addr,
                        input int exp_edges, input logic [31:0] exp_data);
        int e;
        logic [31:0] d;
        logic er;
        int w0;
        w0 = we_cnt;
        access(op, addr, 32'h0, e, d, er);
        check({tag, "_lat"}, e, exp_edges);
        check({tag, "_data"}, d, exp_data);
        check({tag, "_err"}, 32'(er), 32'd0);
        check({tag, "_nowe"}, we_cnt - w0, 32'd0);
        idle(tag);
    endtask

    task automatic store(input string tag, input op_e op, input logic [31:0] addr,
                         input logic [31:0] wdata, input int exp_edges, input logic [31:0] exp_word);
        int e;
        logic [31:0] d;
        logic er;
        int w0;
        w0 = we_cnt;
        access(op, addr, wdata, e, d, er);
        check({tag, "_lat"}, e, exp_edges);
        check({tag, "_err"}, 32'(er), 32'd0);
        check({tag, "_rdata0"}, d, 32'd0);
        check({tag, "_we_pulses"}, we_cnt - w0, 32'd1);
        check({tag, "_we_addr"}, we_addr, {addr[31:2], 2'b00});
        check({tag, "_we_data"}, we_data, exp_word);
        idle(tag);
    endtask

    task automatic misal(input string tag, input op_e op, input logic [31:0] addr);
        int e;
        logic [31:0] d;
        logic er;
        int w0;
        w0 = we_cnt;
        access(op, addr, 32'hCAFE_F00D, e, d, er);
        check({tag, "_lat"}, e, 32'd1);
        check({tag, "_err"}, 32'(er), 32'd1);
        check({tag, "_rdata0"}, d, 32'd0);
        check({tag, "_nowe"}, we_cnt - w0, 32'd0);
        idle(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e, w0, r0;
        logic [31:0] d;
        logic er;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(err_misalign), 32'd0);
        check("rst_stall_idle", 32'(stall), 32'd0);

        req_valid = 1'b1;
        req_op    = OP_LW;
        req_addr  = 32'h100;
        @(posedge clk);
        @(negedge clk);
        check("rst_prio_rv", 32'(resp_valid), 32'd0);
        check("rst_prio_addr", mem_addr, 32'd0);
        check("rst_prio_stall", 32'(stall), 32'd1);
        req_valid = 1'b0;

        pre_we  = 1'b1;
        pre_idx = 8'h40;
        pre_dat = 32'h8877_66F5;
        @(posedge clk);
        @(negedge clk);
        pre_we = 1'b0;
        rst    = 1'b0;

        load("lb_100", OP_LB, 32'h100, 3, 32'hFFFF_FFF5);
        check("lb_mem_addr", mem_addr, 32'h100);
        load("lhu_102", OP_LHU, 32'h102, 3, 32'h0000_8877);
        load("lh_102", OP_LH, 32'h102, 3, 32'hFFFF_8877);
        load("lh_100", OP_LH, 32'h100, 3, 32'h0000_66F5);
        load("lbu_103", OP_LBU, 32'h103, 3, 32'h0000_0088);
        load("lbu_100", OP_LBU, 32'h100, 3, 32'h0000_00F5);
        load("lb_101", OP_LB, 32'h101, 3, 32'h0000_0066);
        load("lw_100", OP_LW, 32'h100, 3, 32'h8877_66F5);

        store("sb_101", OP_SB, 32'h101, 32'h0000_00AB, 4, 32'h8877_ABF5);
        load("lw_after_sb", OP_LW, 32'h100, 3, 32'h8877_ABF5);
        store("sh_102", OP_SH, 32'h102, 32'hFFFF_1234, 4, 32'h1234_ABF5);
        load("lw_after_sh", OP_LW, 32'h100, 3, 32'h1234_ABF5);

        misal("sw_102", OP_SW, 32'h102);
        load("lw_after_mis", OP_LW, 32'h100, 3, 32'h1234_ABF5);
        misal("lh_101", OP_LH, 32'h101);
        misal("lw_103", OP_LW, 32'h103);
        misal("sh_103", OP_SH, 32'h103);
        check("mis_addr_hold", mem_addr, 32'h100);

        stall_bad = 0;
        w0 = we_cnt;
        access(OP_SW, 32'h200, 32'hDEAD_BEEF, e, d, er);
        check("b2b_sw_lat", e, 32'd2);
        check("b2b_sw_we_pulses", we_cnt - w0, 32'd1);
        check("b2b_sw_we_addr", we_addr, 32'h200);
        check("b2b_sw_we_data", we_data, 32'hDEAD_BEEF);
        access(OP_LW, 32'h200, 32'h0, e, d, er);
        check("b2b_lw_lat", e, 32'd4);
        check("b2b_lw_data", d, 32'hDEAD_BEEF);
        check("b2b_lw_err", 32'(er), 32'd0);
        check("b2b_stall", stall_bad, 32'd0);
        idle("b2b");

        w0 = we_cnt;
        r0 = rv_cnt;
        req_valid = 1'b1;
        req_op    = OP_SB;
        req_addr  = 32'h100;
        req_wdata = 32'h0000_0055;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_we", 32'(mem_we), 32'd0);
        check("abort_rv", 32'(resp_valid), 32'd0);
        check("abort_addr", mem_addr, 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort_no_we", we_cnt - w0, 32'd0);
        check("abort_no_rv", rv_cnt - r0, 32'd0);
        load("lw_after_abort", OP_LW, 32'h100, 3, 32'h1234_ABF5);
        check("stall_total", stall_bad, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
